// File: rtl/beep_generator.sv
// Emits `count` beeps of a TONE_DIV square wave separated by OFF_CYCLES of silence.
// Define BEEP_QUEUE_EN to add a one-deep pending request slot honoured at sequence end.
module beep_generator #(
    parameter int unsigned TONE_DIV   = 25000,
    parameter int unsigned ON_CYCLES  = 10000000,
    parameter int unsigned OFF_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] count,
    output logic       buzz,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
    } state_t;

    localparam logic [31:0] TONE_LAST = TONE_DIV - 1;
    localparam logic [31:0] ON_LAST   = ON_CYCLES - 1;
    localparam logic [31:0] OFF_LAST  = OFF_CYCLES - 1;

    state_t      state;
    state_t      state_next;
    logic [2:0]  beeps_left;
    logic [2:0]  beeps_left_next;
    logic [31:0] dur_cnt;
    logic [31:0] dur_cnt_next;
    logic [31:0] tone_cnt;
    logic [31:0] tone_cnt_next;
    logic        tone_phase;
    logic        tone_phase_next;
    logic        done_r;
    logic        done_next;

    // launch/launch_count say whether IDLE starts a sequence this cycle and with how many beeps
    logic        launch;
    logic [2:0]  launch_count;

`ifdef BEEP_QUEUE_EN
    logic        pend_valid;
    logic        pend_valid_next;
    logic [2:0]  pend_count;
    logic [2:0]  pend_count_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_count <= 3'd0;
        end else begin
            pend_valid <= pend_valid_next;
            pend_count <= pend_count_next;
        end
    end

    // A queued request takes priority over an external start in the done cycle
    always_comb begin
        pend_valid_next = pend_valid;
        pend_count_next = pend_count;
        launch          = 1'b0;
        launch_count    = count;
        if (state == IDLE) begin
            if (done_r && pend_valid) begin
                launch          = 1'b1;
                launch_count    = pend_count;
                pend_valid_next = 1'b0;
            end else if (start && (count != 3'd0)) begin
                launch = 1'b1;
            end
        end else if (start && (count != 3'd0) && !pend_valid) begin
            pend_valid_next = 1'b1;
            pend_count_next = count;
        end
    end
`else
    always_comb begin
        launch       = (state == IDLE) && start && (count != 3'd0);
        launch_count = count;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beeps_left <= 3'd0;
            dur_cnt    <= 32'd0;
            tone_cnt   <= 32'd0;
            tone_phase <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state      <= state_next;
            beeps_left <= beeps_left_next;
            dur_cnt    <= dur_cnt_next;
            tone_cnt   <= tone_cnt_next;
            tone_phase <= tone_phase_next;
            done_r     <= done_next;
        end
    end

    always_comb begin
        state_next      = state;
        beeps_left_next = beeps_left;
        dur_cnt_next    = dur_cnt;
        tone_cnt_next   = tone_cnt;
        tone_phase_next = tone_phase;
        done_next       = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_next      = ON;
                    beeps_left_next = launch_count;
                    dur_cnt_next    = 32'd0;
                    tone_cnt_next   = 32'd0;
                    tone_phase_next = 1'b1;
                end
            end
            ON: begin
                if (tone_cnt == TONE_LAST) begin
                    tone_cnt_next   = 32'd0;
                    tone_phase_next = ~tone_phase;
                end else begin
                    tone_cnt_next = tone_cnt + 32'd1;
                end
                // Last beep goes straight to IDLE so no trailing silence is added
                if (dur_cnt == ON_LAST) begin
                    dur_cnt_next    = 32'd0;
                    beeps_left_next = beeps_left - 3'd1;
                    if (beeps_left == 3'd1) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = OFF;
                    end
                end else begin
                    dur_cnt_next = dur_cnt + 32'd1;
                end
            end
            OFF: begin
                if (dur_cnt == OFF_LAST) begin
                    state_next      = ON;
                    dur_cnt_next    = 32'd0;
                    tone_cnt_next   = 32'd0;
                    tone_phase_next = 1'b1;
                end else begin
                    dur_cnt_next = dur_cnt + 32'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign buzz = (state == ON) && tone_phase;
    assign busy = (state != IDLE);
    assign done = done_r;

endmodule

// File: tb/tb_beep_generator.sv
// Directed self-checking bench for beep_generator with TONE_DIV=2, ON_CYCLES=8, OFF_CYCLES=4.
// Cycle c is the interval after clock edge c-1; a start driven in cycle c is sampled at edge c.
module tb_beep_generator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] count;
    logic       buzz;
    logic       busy;
    logic       done;

    int tests;
    int fails;

    beep_generator #(
        .TONE_DIV  (2),
        .ON_CYCLES (8),
        .OFF_CYCLES(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .count(count),
        .buzz (buzz),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {busy, buzz, done} at cycle c for an n-beep sequence whose first busy cycle is s
    function automatic logic [2:0] seq_exp(int c, int s, int n);
        int   len;
        int   pos;
        logic b;
        logic z;
        logic d;
        len = n * 8 + (n - 1) * 4;
        b = (c >= s) && (c < s + len);
        z = 1'b0;
        if (b) begin
            pos = (c - s) % 12;
            z = (pos < 8) && (((pos / 2) % 2) == 0);
        end
        d = (c == s + len);
        return {b, z, d};
    endfunction

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        count = 3'd3;
        step();
        step();
        if ({busy, buzz, done} !== 3'b000) begin
            $display("[TB] FAIL reset_hold: got %b expected 000", {busy, buzz, done});
            fails++;
        end
        tests++;
        rst   = 1'b0;
        start = 1'b0;
        step();
        if ({busy, buzz, done} !== 3'b000) begin
            $display("[TB] FAIL reset_release: got %b expected 000", {busy, buzz, done});
            fails++;
        end
        tests++;
        step();
    endtask

    task automatic test_single();
        logic [2:0] exp;
        start = 1'b1;
        count = 3'd1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            exp = seq_exp(c, 1, 1);
            if ({busy, buzz, done} !== exp) begin
                $display("[TB] FAIL single cycle %0d: got %b expected %b", c, {busy, buzz, done}, exp);
                fails++;
            end
            tests++;
            step();
        end
    endtask

    task automatic test_double();
        logic [2:0] exp;
        start = 1'b1;
        count = 3'd2;
        step();
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            exp = seq_exp(c, 1, 2);
            if ({busy, buzz, done} !== exp) begin
                $display("[TB] FAIL double cycle %0d: got %b expected %b", c, {busy, buzz, done}, exp);
                fails++;
            end
            tests++;
            step();
        end
    endtask

    task automatic test_zero();
        start = 1'b1;
        count = 3'd0;
        step();
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if ({busy, buzz, done} !== 3'b000) begin
                $display("[TB] FAIL zero_count cycle %0d: got %b expected 000", c, {busy, buzz, done});
                fails++;
            end
            tests++;
            step();
        end
    endtask

    task automatic test_reset_abort();
        logic [2:0] exp;
        start = 1'b1;
        count = 3'd3;
        step();
        start = 1'b0;
        for (int c = 1; c <= 28; c++) begin
            exp = (c <= 10) ? seq_exp(c, 1, 3) : seq_exp(c, 16, 1);
            if ({busy, buzz, done} !== exp) begin
                $display("[TB] FAIL reset_abort cycle %0d: got %b expected %b", c, {busy, buzz, done}, exp);
                fails++;
            end
            tests++;
            rst   = (c == 10);
            start = (c == 15);
            count = (c == 15) ? 3'd1 : 3'd0;
            step();
        end
        rst   = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_busy_start();
        logic [2:0] exp;
        start = 1'b1;
        count = 3'd1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            exp = seq_exp(c, 1, 1);
`ifdef BEEP_QUEUE_EN
            exp = exp | seq_exp(c, 10, 2);
`endif
            if ({busy, buzz, done} !== exp) begin
                $display("[TB] FAIL busy_start cycle %0d: got %b expected %b", c, {busy, buzz, done}, exp);
                fails++;
            end
            tests++;
            start = (c == 4);
            count = (c == 4) ? 3'd2 : 3'd0;
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp;
        start = 1'b1;
        count = 3'd1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            exp = seq_exp(c, 1, 1) | seq_exp(c, 10, 1);
            if ({busy, buzz, done} !== exp) begin
                $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", c, {busy, buzz, done}, exp);
                fails++;
            end
            tests++;
            start = (c == 9);
            count = (c == 9) ? 3'd1 : 3'd0;
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b0;
        count = 3'd0;
        test_reset();
        test_single();
        test_double();
        test_zero();
        test_reset_abort();
        test_busy_start();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
